// File: rtl/trigger_ctrl.sv
// trigger_ctrl: scope trigger sequencer with synchronized source select, edge/level
// qualification and post-capture holdoff. Define TRIG_AUTO_TIMEOUT_EN to build in the auto-trigger timer.
module trigger_ctrl #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLDOFF_W   = 16,
    parameter int unsigned AUTO_W      = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         trig_in,
    input  logic [$clog2(NUM_SRC)-1:0] src_sel,
    input  logic [1:0]                 edge_mode,
    input  logic                       trig_en,
    input  logic                       armed,
    input  logic                       set_capture_done,
    input  logic [HOLDOFF_W-1:0]       holdoff,
    input  logic [AUTO_W-1:0]          auto_timeout,
    output logic                       triggered,
    output logic                       auto_trig,
    output logic [2:0]                 trig_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ARMED = 3'd2,
        ST_TRIG  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [HOLDOFF_W-1:0]   hold_cnt;
    logic                   sel_bit_c;
    logic                   cur_c;
    logic                   event_c;
    logic                   hold_done_c;
    logic                   auto_fire_c;

    // Out-of-range selects fall back to source 0; the mux sits ahead of the synchronizer.
    always_comb begin
        sel_bit_c = trig_in[0];
        if (32'(src_sel) < NUM_SRC) begin
            sel_bit_c = trig_in[src_sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sel_bit_c};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign cur_c = sync_q[SYNC_STAGES-1];

    always_comb begin
        event_c = 1'b0;
        case (edge_mode)
            2'b00:   event_c = ~cur_c & hist_q;
            2'b01:   event_c = cur_c & ~hist_q;
            2'b10:   event_c = cur_c ^ hist_q;
            default: event_c = cur_c;
        endcase
    end

    // A holdoff reprogrammed to zero mid-hold releases immediately.
    assign hold_done_c = (holdoff == '0) || (hold_cnt >= holdoff - HOLDOFF_W'(1));

`ifdef TRIG_AUTO_TIMEOUT_EN
    logic [AUTO_W-1:0] auto_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (state != ST_ARMED) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
        end
    end

    assign auto_fire_c = (auto_timeout != '0) && (auto_cnt == auto_timeout - AUTO_W'(1));
`else
    logic unused_auto_c;

    assign unused_auto_c = ^auto_timeout;
    assign auto_fire_c   = 1'b0;
`endif

    // Sequencer; a real event takes precedence over a coincident timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            triggered <= 1'b0;
            auto_trig <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig_en) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!trig_en)  state <= ST_IDLE;
                    else if (armed) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!trig_en) begin
                        state <= ST_IDLE;
                    end else if (armed && event_c) begin
                        state     <= ST_TRIG;
                        triggered <= 1'b1;
                        auto_trig <= 1'b0;
                    end else if (auto_fire_c) begin
                        state     <= ST_TRIG;
                        triggered <= 1'b1;
                        auto_trig <= 1'b1;
                    end
                end
                ST_TRIG: begin
                    if (set_capture_done) begin
                        triggered <= 1'b0;
                        auto_trig <= 1'b0;
                        hold_cnt  <= '0;
                        state     <= (holdoff == '0) ? ST_WAIT : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!trig_en) begin
                        state <= ST_IDLE;
                    end else if (hold_done_c) begin
                        state <= ST_WAIT;
                    end else begin
                        hold_cnt <= hold_cnt + HOLDOFF_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    triggered <= 1'b0;
                    auto_trig <= 1'b0;
                end
            endcase
        end
    end

    assign trig_state = 3'(state);

endmodule

// File: tb/tb_trigger_ctrl.sv
// tb_trigger_ctrl: directed scenarios plus randomized traffic for trigger_ctrl,
// checked against a sample-history reference model. Honors TRIG_AUTO_TIMEOUT_EN.
module tb_trigger_ctrl;

    localparam int unsigned NUM_SRC   = 4;
    localparam int unsigned SYNC      = 2;
    localparam int unsigned HOLDOFF_W = 16;
    localparam int unsigned AUTO_W    = 20;
    localparam int unsigned SEL_W     = $clog2(NUM_SRC);
`ifdef TRIG_AUTO_TIMEOUT_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    localparam logic [4:0] V_IDLE  = 5'b00000;
    localparam logic [4:0] V_WAIT  = 5'b00001;
    localparam logic [4:0] V_ARMED = 5'b00010;
    localparam logic [4:0] V_TRIG  = 5'b10011;
    localparam logic [4:0] V_AUTO  = 5'b11011;
    localparam logic [4:0] V_HOLD  = 5'b00100;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_SRC-1:0]   trig_in;
    logic [SEL_W-1:0]     src_sel;
    logic [1:0]           edge_mode;
    logic                 trig_en;
    logic                 armed;
    logic                 set_capture_done;
    logic [HOLDOFF_W-1:0] holdoff;
    logic [AUTO_W-1:0]    auto_timeout;
    logic                 triggered;
    logic                 auto_trig;
    logic [2:0]           trig_state;
    logic [4:0]           obs;

    int tests = 0;
    int fails = 0;

    // Reference model: phase number, cycles spent in phase, and selected-input history.
    int m_state;
    int m_dwell;
    bit m_auto;
    bit samples[$];

    trigger_ctrl #(
        .NUM_SRC(NUM_SRC), .SYNC_STAGES(SYNC), .HOLDOFF_W(HOLDOFF_W), .AUTO_W(AUTO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .src_sel(src_sel),
        .edge_mode(edge_mode), .trig_en(trig_en), .armed(armed),
        .set_capture_done(set_capture_done), .holdoff(holdoff),
        .auto_timeout(auto_timeout), .triggered(triggered), .auto_trig(auto_trig),
        .trig_state(trig_state)
    );

    assign obs = {triggered, auto_trig, trig_state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_state = 0;
        m_dwell = 0;
        m_auto  = 1'b0;
        samples.delete();
        for (int i = 0; i <= int'(SYNC); i++) samples.push_back(1'b0);
    endfunction

    // One clock edge: the detector sees the input sampled SYNC edges ago and the one before it.
    function automatic void model_step();
        bit s, h, ev;
        int nxt, sel;
        s = samples[1];
        h = samples[0];
        case (edge_mode)
            2'b00:   ev = h && !s;
            2'b01:   ev = s && !h;
            2'b10:   ev = s != h;
            default: ev = s;
        endcase
        nxt = m_state;
        case (m_state)
            0: if (trig_en) nxt = 1;
            1: begin
                if (!trig_en) nxt = 0;
                else if (armed) nxt = 2;
            end
            2: begin
                if (!trig_en) nxt = 0;
                else if (armed && ev) begin
                    nxt = 3; m_auto = 1'b0;
                end else if (AUTO_ON && auto_timeout != 0 && m_dwell + 1 == int'(auto_timeout)) begin
                    nxt = 3; m_auto = 1'b1;
                end
            end
            3: if (set_capture_done) nxt = (holdoff == 0) ? 1 : 4;
            default: begin
                if (!trig_en) nxt = 0;
                else if (m_dwell + 1 >= int'(holdoff)) nxt = 1;
            end
        endcase
        if (nxt != 3) m_auto = 1'b0;
        m_dwell = (nxt == m_state) ? m_dwell + 1 : 0;
        m_state = nxt;
        sel = (int'(src_sel) < int'(NUM_SRC)) ? int'(src_sel) : 0;
        samples.push_back(trig_in[sel]);
        void'(samples.pop_front());
    endfunction

    function automatic logic [4:0] model_vec();
        return {(m_state == 3), m_auto, 3'(m_state)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic go_armed();
        if (m_state == 3) begin
            holdoff = '0;
            set_capture_done = 1'b1;
            tick();
            set_capture_done = 1'b0;
        end
        trig_en = 1'b0;
        armed   = 1'b0;
        repeat (4) tick();
        trig_en = 1'b1;
        armed   = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trig_in = '0; src_sel = '0; edge_mode = 2'b01; trig_en = 1'b0;
        armed = 1'b0; set_capture_done = 1'b0; holdoff = '0; auto_timeout = '0;
        model_reset();
        #1;
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL reset_async: got %b expected %b", obs, V_IDLE); end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL reset_held: got %b expected %b", obs, V_IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL reset_release: got %b expected %b", obs, V_IDLE); end
    endtask

    task automatic test_rising_latency();
        src_sel = SEL_W'(2); edge_mode = 2'b01; trig_in = '0;
        go_armed();
        tests++;
        if (obs !== V_ARMED) begin fails++; $display("FAIL rise_armed: got %b expected %b", obs, V_ARMED); end
        trig_in[2] = 1'b1;
        tick();
        tick();
        tests++;
        if (obs !== V_ARMED) begin fails++; $display("FAIL rise_k1: got %b expected %b", obs, V_ARMED); end
        tick();
        tests++;
        if (obs !== V_TRIG) begin fails++; $display("FAIL rise_k2: got %b expected %b", obs, V_TRIG); end
    endtask

    task automatic test_holdoff();
        holdoff = HOLDOFF_W'(5);
        set_capture_done = 1'b1;
        tick();
        set_capture_done = 1'b0;
        armed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (obs !== V_HOLD) begin fails++; $display("FAIL hold_cycle%0d: got %b expected %b", i, obs, V_HOLD); end
            tick();
        end
        tests++;
        if (obs !== V_WAIT) begin fails++; $display("FAIL hold_exit: got %b expected %b", obs, V_WAIT); end
        // Level already high on entry: triggers on the first ARMED cycle.
        edge_mode = 2'b11;
        go_armed();
        tests++;
        if (obs !== V_ARMED) begin fails++; $display("FAIL level_entry: got %b expected %b", obs, V_ARMED); end
        tick();
        tests++;
        if (obs !== V_TRIG) begin fails++; $display("FAIL level_first: got %b expected %b", obs, V_TRIG); end
        holdoff = '0;
        set_capture_done = 1'b1;
        tick();
        set_capture_done = 1'b0;
        tests++;
        if (obs !== V_WAIT) begin fails++; $display("FAIL hold_zero: got %b expected %b", obs, V_WAIT); end
    endtask

    task automatic test_level();
        src_sel = SEL_W'(3); edge_mode = 2'b11; trig_in = '0;
        go_armed();
        set_capture_done = 1'b1;
        tick();
        set_capture_done = 1'b0;
        tests++;
        if (obs !== V_ARMED) begin fails++; $display("FAIL capdone_ignored: got %b expected %b", obs, V_ARMED); end
        trig_in[3] = 1'b1;
        tick();
        tick();
        tests++;
        if (obs !== V_ARMED) begin fails++; $display("FAIL level_k1: got %b expected %b", obs, V_ARMED); end
        tick();
        tests++;
        if (obs !== V_TRIG) begin fails++; $display("FAIL level_k2: got %b expected %b", obs, V_TRIG); end
    endtask

    task automatic test_either_edge();
        src_sel = SEL_W'(1); edge_mode = 2'b10; trig_in = '0;
        go_armed();
        trig_in[1] = 1'b1;
        repeat (3) tick();
        tests++;
        if (obs !== V_TRIG) begin fails++; $display("FAIL either_rise: got %b expected %b", obs, V_TRIG); end
        go_armed();
        tests++;
        if (obs !== V_ARMED) begin fails++; $display("FAIL either_steady: got %b expected %b", obs, V_ARMED); end
        trig_in[1] = 1'b0;
        repeat (2) tick();
        tests++;
        if (obs !== V_ARMED) begin fails++; $display("FAIL either_fall_k1: got %b expected %b", obs, V_ARMED); end
        tick();
        tests++;
        if (obs !== V_TRIG) begin fails++; $display("FAIL either_fall: got %b expected %b", obs, V_TRIG); end
    endtask

    task automatic test_enable_race();
        src_sel = SEL_W'(0); edge_mode = 2'b01; trig_in = '0;
        go_armed();
        trig_in[0] = 1'b1;
        repeat (2) tick();
        trig_en = 1'b0;
        tick();
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL enable_race: got %b expected %b", obs, V_IDLE); end
        trig_en = 1'b1;
    endtask

    task automatic test_auto();
        logic [4:0] exp_fire;
        logic [4:0] exp_rel;
        exp_fire = AUTO_ON ? V_AUTO : V_ARMED;
        exp_rel  = AUTO_ON ? V_WAIT : V_ARMED;
        // Real event on the timeout cycle wins.
        src_sel = SEL_W'(0); edge_mode = 2'b01; trig_in = '0; auto_timeout = AUTO_W'(3);
        go_armed();
        trig_in[0] = 1'b1;
        repeat (3) tick();
        tests++;
        if (obs !== V_TRIG) begin fails++; $display("FAIL auto_real_wins: got %b expected %b", obs, V_TRIG); end
        auto_timeout = AUTO_W'(100);
        go_armed();
        repeat (99) tick();
        tests++;
        if (obs !== V_ARMED) begin fails++; $display("FAIL auto_early: got %b expected %b", obs, V_ARMED); end
        tick();
        tests++;
        if (obs !== exp_fire) begin fails++; $display("FAIL auto_fire: got %b expected %b", obs, exp_fire); end
        repeat (60) tick();
        tests++;
        if (obs !== exp_fire) begin fails++; $display("FAIL auto_hold: got %b expected %b", obs, exp_fire); end
        holdoff = '0;
        set_capture_done = 1'b1;
        tick();
        set_capture_done = 1'b0;
        tests++;
        if (obs !== exp_rel) begin fails++; $display("FAIL auto_release: got %b expected %b", obs, exp_rel); end
        auto_timeout = '0;
    endtask

    task automatic test_reset_mid();
        src_sel = SEL_W'(3); edge_mode = 2'b11; trig_in = '0; trig_in[3] = 1'b1;
        go_armed();
        tick();
        tests++;
        if (obs !== V_TRIG) begin fails++; $display("FAIL rstmid_trig: got %b expected %b", obs, V_TRIG); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (obs !== V_IDLE) begin fails++; $display("FAIL rstmid_async: got %b expected %b", obs, V_IDLE); end
        #1;
        rst_n = 1'b1;
        tick();
        tests++;
        if (obs !== V_WAIT) begin fails++; $display("FAIL rstmid_restart: got %b expected %b", obs, V_WAIT); end
    endtask

    task automatic test_random();
        logic [4:0] exp;
        for (int c = 0; c < 3000; c++) begin
            trig_in = trig_in ^ (NUM_SRC'($urandom) & NUM_SRC'($urandom));
            trig_en = ($urandom_range(0, 19) != 0);
            armed   = ($urandom_range(0, 3) != 0);
            set_capture_done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) src_sel = SEL_W'($urandom_range(0, NUM_SRC - 1));
            if ($urandom_range(0, 39) == 0) edge_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) holdoff = HOLDOFF_W'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) auto_timeout = AUTO_W'($urandom_range(0, 25));
            if ($urandom_range(0, 699) == 0) begin
                #1;
                rst_n = 1'b0;
                model_reset();
                #1;
                tests++;
                if (obs !== V_IDLE) begin fails++; $display("FAIL rand_reset c%0d: got %b expected %b", c, obs, V_IDLE); end
                rst_n = 1'b1;
            end
            tick();
            exp = model_vec();
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL rand c%0d: got %b expected %b", c, obs, exp);
            end
        end
        set_capture_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rising_latency();
        test_holdoff();
        test_level();
        test_either_edge();
        test_enable_race();
        test_auto();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
